// File: rtl/init_pos_unpacker_if.sv
// init_pos_unpacker_if: AXI-Stream beat channel feeding the position-cache unpacker
interface init_pos_unpacker_if #(
  parameter int TDATA_WIDTH = 512
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/init_pos_unpacker.sv
// init_pos_unpacker: splits AXI-Stream beats into per-cell position cache init writes
module init_pos_unpacker #(
  parameter int AXIS_TDATA_WIDTH       = 512,
  parameter int SUB_PACKET_WIDTH       = 128,
  parameter int NUM_SUB_PACKETS        = AXIS_TDATA_WIDTH / SUB_PACKET_WIDTH,
  parameter int NUM_CELLS              = 8,
  parameter int NUM_INIT_STEPS         = (NUM_CELLS + NUM_SUB_PACKETS - 1) / NUM_SUB_PACKETS,
  parameter int NUM_PARTICLES_PER_CELL = 128,
  parameter int ADDR_WIDTH             = $clog2(NUM_PARTICLES_PER_CELL),
  parameter int OFFSET_WIDTH           = 23,
  parameter int ELEMENT_WIDTH          = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_start,
  init_pos_unpacker_if.slave                            s_axis,
  output logic [ADDR_WIDTH-1:0]                         o_init_wr_addr,
  output logic [NUM_CELLS-1:0][3*OFFSET_WIDTH-1:0]      o_init_data,
  output logic [NUM_CELLS-1:0][ELEMENT_WIDTH-1:0]       o_init_element,
  output logic [NUM_INIT_STEPS-1:0]                     o_init_wr_en,
  output logic                                          o_busy,
  output logic                                          o_init_done,
  output logic                                          o_err
);
  localparam int STEP_W = NUM_INIT_STEPS > 1 ? $clog2(NUM_INIT_STEPS) : 1;
  localparam int DW     = 3 * OFFSET_WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_n;
  logic [STEP_W-1:0] step;
  logic [ADDR_WIDTH-1:0] addr;
  logic acc, last_step, final_beat, unused_bits;
  logic [NUM_SUB_PACKETS-1:0][SUB_PACKET_WIDTH-1:0] slots;
  assign slots          = s_axis.tdata;
  assign unused_bits    = ^s_axis.tdata;
  assign s_axis.tready  = state == LOAD;
  assign o_busy         = state == LOAD;
  assign o_init_done    = state == DONE;
  always_comb begin
    acc        = s_axis.tvalid && s_axis.tready;
    last_step  = step == STEP_W'(NUM_INIT_STEPS - 1);
    final_beat = last_step && addr == ADDR_WIDTH'(NUM_PARTICLES_PER_CELL - 1);
    state_n    = state;
    if (state == LOAD)
      state_n = acc && (final_beat || s_axis.tlast) ? DONE : LOAD;
    else
      state_n = i_start ? LOAD : state;
  end
  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!rst) begin
      step           <= '0;
      addr           <= '0;
      o_init_wr_addr <= '0;
      o_init_data    <= '0;
      o_init_element <= '0;
      o_init_wr_en   <= '0;
      o_err          <= 1'b0;
    end else begin
      o_init_wr_en <= '0;
      if (acc) begin
        o_init_wr_addr <= addr;
        o_init_wr_en   <= NUM_INIT_STEPS'(1) << step;
        step           <= last_step ? '0 : step + 1'b1;
        addr           <= last_step && !final_beat ? addr + 1'b1 : addr;
        o_err          <= final_beat ^ s_axis.tlast;
        for (int c = 0; c < NUM_CELLS; c++)
          if (step == STEP_W'(c / NUM_SUB_PACKETS)) begin
            o_init_data[c]    <= slots[c % NUM_SUB_PACKETS][SUB_PACKET_WIDTH-1] ?
                                 slots[c % NUM_SUB_PACKETS][DW-1:0] : '0;
            o_init_element[c] <= slots[c % NUM_SUB_PACKETS][SUB_PACKET_WIDTH-1] ?
                                 slots[c % NUM_SUB_PACKETS][DW +: ELEMENT_WIDTH] : '0;
          end
      end else if (state != LOAD && i_start) begin
        step  <= '0;
        addr  <= '0;
        o_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_init_pos_unpacker.sv
// tb_init_pos_unpacker: randomized self-checking bench against a beat-count reference model
module tb_init_pos_unpacker;
  localparam int NSP = 4, NC = 8, NIS = 2, NPC = 128, AW = 7, DW = 69;
  logic clk = 1'b0, rst = 1'b0, i_start = 1'b0;
  always #5 clk = ~clk;
  init_pos_unpacker_if #(.TDATA_WIDTH(512)) axis ();
  init_pos_unpacker_if #(.TDATA_WIDTH(512)) axis6 ();
  assign axis6.tdata  = axis.tdata;
  assign axis6.tvalid = axis.tvalid;
  assign axis6.tlast  = axis.tlast;
  logic [AW-1:0] wr_addr;
  logic [NC-1:0][DW-1:0] data;
  logic [NC-1:0][1:0] elem;
  logic [NIS-1:0] wr_en;
  logic busy, done, err;
  logic [1:0] wr_addr6;
  logic [5:0][DW-1:0] data6;
  logic [5:0][1:0] elem6;
  logic [1:0] wr_en6;
  logic busy6, done6, err6;
  init_pos_unpacker dut (
    .clk(clk), .rst(rst), .i_start(i_start), .s_axis(axis),
    .o_init_wr_addr(wr_addr), .o_init_data(data), .o_init_element(elem),
    .o_init_wr_en(wr_en), .o_busy(busy), .o_init_done(done), .o_err(err)
  );
  init_pos_unpacker #(.NUM_CELLS(6), .NUM_PARTICLES_PER_CELL(4), .ADDR_WIDTH(2)) dut6 (
    .clk(clk), .rst(rst), .i_start(i_start), .s_axis(axis6),
    .o_init_wr_addr(wr_addr6), .o_init_data(data6), .o_init_element(elem6),
    .o_init_wr_en(wr_en6), .o_busy(busy6), .o_init_done(done6), .o_err(err6)
  );
  int errors = 0, checks = 0, writes = 0;
  int mode = 0, n = 0;
  logic [NC-1:0][DW-1:0] e_data;
  logic [NC-1:0][1:0] e_elem;
  logic [AW-1:0] e_addr;
  logic [NIS-1:0] e_wr;
  logic e_err;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW+1:0] dec(input logic [511:0] b, input int k);
    logic [127:0] s;
    s = b[k*128 +: 128];
    return s[127] ? s[DW+1:0] : '0;
  endfunction
  function automatic logic [511:0] make_beat(input int b, input int m);
    logic [511:0] r;
    int a, st, c;
    a = b / NIS;
    st = b % NIS;
    for (int k = 0; k < NSP; k++) begin
      c = st * NSP + k;
      r[k*128 +: 128] = m == 0 ? {1'b1, 56'($urandom), 2'(c % 3), 23'h7FFFFF, 23'(a), 23'(c)}
                               : {$urandom, $urandom, $urandom, $urandom};
    end
    if (m == 1 && b == 0) r[255] = 1'b0;
    return r;
  endfunction
  task automatic model();
    bit fin;
    int g, c;
    if (!rst) begin
      mode = 0; n = 0; e_data = '0; e_elem = '0; e_addr = '0; e_wr = '0; e_err = 1'b0;
    end else begin
      e_wr = '0;
      if (mode == 1 && axis.tvalid) begin
        g = n % NIS;
        for (int k = 0; k < NSP; k++) begin
          c = g * NSP + k;
          if (c < NC) {e_elem[c], e_data[c]} = dec(axis.tdata, k);
        end
        e_addr = AW'(n / NIS);
        e_wr = NIS'(1 << g);
        fin = n == NIS * NPC - 1;
        n++;
        if (fin || axis.tlast) begin
          mode = 2;
          e_err = fin ? !axis.tlast : 1'b1;
        end
      end else if (mode != 1 && i_start) begin
        mode = 1; n = 0; e_err = 1'b0;
      end
    end
  endtask
  task automatic compare();
    chk("tready", axis.tready, mode == 1);
    chk("busy", busy, mode == 1);
    chk("done", done, mode == 2);
    chk("err", err, e_err);
    chk("wr_en", wr_en, e_wr);
    chk("wr_addr", wr_addr, e_addr);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("data%0d", c), data[c], e_data[c]);
      chk($sformatf("elem%0d", c), elem[c], e_elem[c]);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    #1;
    compare();
    if (wr_en != '0) writes++;
  endtask
  task automatic run_load(input int nb, input int tl, input bit gaps, input int m, input bit pad);
    logic [511:0] b0, b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        axis.tvalid = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
      end
      axis.tdata = make_beat(b, m);
      axis.tvalid = 1'b1;
      axis.tlast = b + 1 == tl;
      i_start = gaps && b == 5;
      if (b == 0) b0 = axis.tdata;
      if (b == 1) b1 = axis.tdata;
      tick();
      i_start = 1'b0;
      if (pad && b == 0) begin
        chk("pad_wr0", wr_en6, 2'b01);
        for (int c = 0; c < 4; c++) chk($sformatf("pad_g0_%0d", c), {elem6[c], data6[c]}, dec(b0, c));
      end
      if (pad && b == 1) begin
        chk("pad_wr1", wr_en6, 2'b10);
        for (int c = 0; c < 4; c++) chk($sformatf("pad_hold_%0d", c), {elem6[c], data6[c]}, dec(b0, c));
        for (int c = 4; c < 6; c++) chk($sformatf("pad_g1_%0d", c), {elem6[c], data6[c]}, dec(b1, c - 4));
      end
    end
    axis.tlast = 1'b0;
    axis.tvalid = tl != 0;
    axis.tdata = make_beat(0, 1);
    repeat (3) tick();
    axis.tvalid = 1'b0;
  endtask
  initial begin
    int w0;
    axis.tdata = make_beat(0, 1);
    axis.tlast = 1'b0;
    axis.tvalid = 1'b1;
    repeat (3) tick();
    chk("rst_writes", writes, 0);
    axis.tvalid = 1'b0;
    rst = 1'b1;
    tick();
    w0 = writes;
    run_load(256, 256, 1'b0, 0, 1'b1);
    chk("full_writes", writes - w0, 256);
    chk("full_done", done, 1'b1);
    chk("full_err", err, 1'b0);
    w0 = writes;
    run_load(256, 256, 1'b1, 1, 1'b0);
    chk("gap_writes", writes - w0, 256);
    w0 = writes;
    run_load(10, 10, 1'b0, 1, 1'b0);
    chk("early_writes", writes - w0, 10);
    chk("early_err", err, 1'b1);
    run_load(256, 0, 1'b0, 1, 1'b0);
    chk("nolast_err", err, 1'b1);
    chk("nolast_done", done, 1'b1);
    run_load(37, 0, 1'b0, 1, 1'b0);
    chk("restart_err", err, 1'b0);
    rst = 1'b0;
    axis.tvalid = 1'b1;
    tick();
    rst = 1'b1;
    w0 = writes;
    repeat (3) tick();
    chk("rst_mid_writes", writes - w0, 0);
    axis.tvalid = 1'b0;
    run_load(4, 0, 1'b0, 1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/init_pos_unpacker.md
Name: init_pos_unpacker

Overview:
- Upstream feeder of the per-cell position caches during initialization.
- Accepts 512-bit AXI-Stream beats from the host/DMA and splits each beat into NUM_SUB_PACKETS 128-bit sub-packets, one per cell of a cell group.
- Drives the caches' shared init write address, per-cell offset/element data, and per-group write enables.
- Sequences groups and particle addresses until every cell slot has been loaded, then flags completion.

Parameters:
- AXIS_TDATA_WIDTH, 512, stream data width.
- SUB_PACKET_WIDTH, 128, bits per cell slot within a beat.
- NUM_SUB_PACKETS, 4, AXIS_TDATA_WIDTH/SUB_PACKET_WIDTH; cells per group.
- NUM_CELLS, 8, local cells (X_DIM*Y_DIM*Z_DIM).
- NUM_INIT_STEPS, 2, ceil(NUM_CELLS/NUM_SUB_PACKETS); groups per particle address.
- NUM_PARTICLES_PER_CELL, 128, address depth per cell.
- ADDR_WIDTH, 7, $clog2(NUM_PARTICLES_PER_CELL).
- OFFSET_WIDTH, 23, per-axis fixed-point offset width.
- ELEMENT_WIDTH, 2, element code width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  one clock; reset is synchronous and active-low.
- i_start  in  1  one-cycle pulse; arms a load; ignored while in LOAD.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  beat; sub-packet k = bits [128k+127:128k].
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of the load.
- s_axis_tready  out  1  asserted only in LOAD.
- o_init_wr_addr  out  ADDR_WIDTH  particle address for current write.
- o_init_data  out  NUM_CELLS x 3*OFFSET_WIDTH  per-cell {z,y,x} offset.
- o_init_element  out  NUM_CELLS x ELEMENT_WIDTH  per-cell element.
- o_init_wr_en  out  NUM_INIT_STEPS  one-hot group write enable.
- o_busy  out  1  high in LOAD.
- o_init_done  out  1  level, high in DONE.
- o_err  out  1  sticky framing error; cleared by i_start or reset.

Behaviour:
- Sub-packet format:
  - [68:0] = {z,y,x} offsets (x in [22:0]).
  - [70:69] = element.
  - [127] = slot valid.
  - [126:71] reserved; ignored.
- Invalid slot (bit127=0): the cell's o_init_data and o_init_element are written as all-zero (empty slot).
- Cell index mapping: cell = step*NUM_SUB_PACKETS + k. Slots with cell >= NUM_CELLS (padding) are dropped.
- Reset (rst=0 at a clk edge):
  - State IDLE; step=0; addr=0.
  - All outputs 0, including tready, wr_en, data, element, busy, done, and err.
  - Applies mid-LOAD too: the partial load is abandoned, with no further wr_en pulses.
- States:
  - IDLE: tready=0. i_start -> LOAD, clear step, addr, and err.
  - LOAD: tready=1. On an accepted beat (tvalid & tready):
    - Latch that group's slots into o_init_data/o_init_element for cells of group step; other cells hold their values.
    - o_init_wr_addr <= addr; o_init_wr_en <= one-hot(step) for exactly one cycle.
    - Latency: accepted beat at edge N -> wr_en/data/addr valid in cycle after edge N.
    - step increments. At step==NUM_INIT_STEPS-1, step wraps to 0 and addr increments.
  - Final beat (addr==NUM_PARTICLES_PER_CELL-1 and step==NUM_INIT_STEPS-1) -> DONE. If tlast=0 on that beat, set o_err.
  - Early tlast (any accepted beat before the final one): that beat is still written, then -> DONE with o_err=1.
  - DONE: tready=0, o_init_done=1, wr_en=0. i_start -> LOAD (done drops the next cycle; err cleared).
- No beat is accepted in IDLE or DONE. The upstream stream must stall (backpressure).
- tvalid low in LOAD: counters and outputs hold; wr_en=0.
- i_start in the same cycle as an accepted beat in LOAD: i_start is ignored.
- No arithmetic on payload; pure bit slicing. addr never exceeds NUM_PARTICLES_PER_CELL-1; there is no wrap past the end.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles with tvalid=1 -> tready=0, all outputs 0, no wr_en.
- Full load: i_start, then 256 beats with tlast on beat 256, each slot payload = {valid=1, element=cell%3, x=cell, y=addr, z=0x7FFFFF} -> 256 wr_en pulses alternating 01/10, addr 0..127 each twice, done=1, err=0, tready=0 afterwards.
- Backpressure/gaps: randomly deassert tvalid for 1-5 cycles -> identical write sequence to the full-load case, no duplicate or missing pulse.
- Invalid and padding slots: beat with slot1 bit127=0 -> cell1 data=0, element=0, with other cells correct. With NUM_CELLS=6, slots 2-3 of group 1 never alter outputs.
- Framing errors: tlast on beat 10 -> 10 writes then DONE with err=1. Full 256 beats with tlast=0 -> DONE with err=1. Then re-issue i_start -> err=0 and a fresh load starts at addr 0.
- Reset mid-load: rst=0 after beat 37 -> IDLE, no further wr_en. The next i_start restarts at step 0, addr 0.
